// File: rtl/csr_access_ctrl_pkg.sv
// Shared definitions for the CSR access sequencer: op encodings, state
// encoding and common constants.
package csr_access_ctrl_pkg;

  localparam int REG_DATA_WIDTH = 32;

  localparam logic [REG_DATA_WIDTH-1:0] ZERO_WORD  = '0;
  localparam logic                      INT_ASSERT = 1'b1;

  // 00 never reaches the register file as a write; it degrades to read-only.
  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_EXU_RD   = 3'd1,
    ST_EXU_WR   = 3'd2,
    ST_EXU_RESP = 3'd3,
    ST_INT_WR   = 3'd4
  } csr_state_e;

endpackage

// File: rtl/csr_access_ctrl_wdata_calc.sv
// Read-modify-write data function for CSRRW/CSRRS/CSRRC.
// An illegal op returns the old value unchanged.
module csr_wdata_calc
  import csr_access_ctrl_pkg::*;
#(
  parameter int DATA_W = REG_DATA_WIDTH
) (
  input  csr_op_e           op,
  input  logic [DATA_W-1:0] old_val,
  input  logic [DATA_W-1:0] op1,
  output logic [DATA_W-1:0] wdata
);

  always_comb begin
    wdata = old_val;
    case (op)
      CSR_OP_RW: wdata = op1;
      CSR_OP_RS: wdata = old_val | op1;
      CSR_OP_RC: wdata = old_val & ~op1;
      default:   wdata = old_val;
    endcase
  end

endmodule

// File: rtl/csr_access_ctrl.sv
// Arbiter/sequencer for the single-ported CSR file: interrupt-controller writes
// have fixed priority over EXU read-modify-write accesses, which int_assert flushes.
module csr_access_ctrl
  import csr_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = REG_DATA_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exu_req_valid_i,
  output logic              exu_req_ready_o,
  input  logic [ADDR_W-1:0] exu_csr_addr_i,
  input  logic [1:0]        exu_op_i,
  input  logic              exu_wen_i,
  input  logic [DATA_W-1:0] exu_op1_i,
  output logic              exu_resp_valid_o,
  input  logic              exu_resp_ready_i,
  output logic [DATA_W-1:0] exu_resp_rdata_o,
  input  logic              int_assert_i,
  input  logic              int_req_valid_i,
  output logic              int_req_ready_o,
  input  logic [ADDR_W-1:0] int_csr_addr_i,
  input  logic [DATA_W-1:0] int_csr_wdata_i,
  output logic [ADDR_W-1:0] csr_raddr_o,
  input  logic [DATA_W-1:0] csr_rdata_i,
  output logic              csr_we_o,
  output logic [ADDR_W-1:0] csr_waddr_o,
  output logic [DATA_W-1:0] csr_wdata_o,
  output logic              busy_o
);

  csr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;   // EXU op1 or INT write data, whichever was accepted
  logic [DATA_W-1:0] old_q;
  csr_op_e           op_q;
  logic              wen_q;
  logic              int_accept, exu_accept, exu_rdy, flush;
  logic [DATA_W-1:0] calc_wdata;

  assign flush = (int_assert_i == INT_ASSERT);

  csr_wdata_calc #(.DATA_W(DATA_W)) u_wdata_calc (
    .op      (op_q),
    .old_val (old_q),
    .op1     (data_q),
    .wdata   (calc_wdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      old_q   <= '0;
      op_q    <= CSR_OP_NONE;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (int_accept) begin
        addr_q <= int_csr_addr_i;
        data_q <= int_csr_wdata_i;
        op_q   <= CSR_OP_NONE;
        wen_q  <= 1'b0;
      end else if (exu_accept) begin
        addr_q <= exu_csr_addr_i;
        data_q <= exu_op1_i;
        op_q   <= csr_op_e'(exu_op_i);
        wen_q  <= exu_wen_i;
      end
      if (state_q == ST_EXU_RD) old_q <= csr_rdata_i;
    end
  end

  // Every output is forced to zero while rst is high, including the readys.
  always_comb begin
    state_d          = state_q;
    int_accept       = 1'b0;
    exu_accept       = 1'b0;
    exu_rdy          = 1'b0;
    int_req_ready_o  = 1'b0;
    exu_req_ready_o  = 1'b0;
    csr_raddr_o      = '0;
    csr_we_o         = 1'b0;
    csr_waddr_o      = '0;
    csr_wdata_o      = '0;
    exu_resp_valid_o = 1'b0;
    exu_resp_rdata_o = '0;
    busy_o           = 1'b0;
    if (rst) begin
      state_d = ST_IDLE;
    end else begin
      busy_o = (state_q != ST_IDLE);
      case (state_q)
        ST_IDLE: begin
          exu_rdy         = !int_req_valid_i && !flush;
          int_req_ready_o = 1'b1;
          exu_req_ready_o = exu_rdy;
          if (int_req_valid_i) begin
            int_accept = 1'b1;
            state_d    = ST_INT_WR;
          end else if (exu_req_valid_i && exu_rdy) begin
            exu_accept = 1'b1;
            state_d    = ST_EXU_RD;
          end
        end
        ST_INT_WR: begin
          csr_we_o    = 1'b1;
          csr_waddr_o = addr_q;
          csr_wdata_o = data_q;
          state_d     = ST_IDLE;
        end
        ST_EXU_RD: begin
          csr_raddr_o = addr_q;
          state_d     = flush ? ST_IDLE : ST_EXU_WR;
        end
        ST_EXU_WR: begin
          if (wen_q && (op_q != CSR_OP_NONE) && !flush) begin
            csr_we_o    = 1'b1;
            csr_waddr_o = addr_q;
            csr_wdata_o = calc_wdata;
          end
          if (!flush) begin
            exu_resp_valid_o = 1'b1;
            exu_resp_rdata_o = old_q;
          end
          state_d = (flush || exu_resp_ready_i) ? ST_IDLE : ST_EXU_RESP;
        end
        ST_EXU_RESP: begin
          if (!flush) begin
            exu_resp_valid_o = 1'b1;
            exu_resp_rdata_o = old_q;
          end
          if (flush || exu_resp_ready_i) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Bench for csr_access_ctrl: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_csr_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        exu_req_valid, exu_req_ready, exu_wen, exu_resp_valid, exu_resp_ready;
  logic [11:0] exu_csr_addr, int_csr_addr, csr_raddr, csr_waddr;
  logic [1:0]  exu_op;
  logic [31:0] exu_op1, exu_resp_rdata, int_csr_wdata, csr_rdata, csr_wdata;
  logic        int_assert, int_req_valid, int_req_ready, csr_we, busy;

  logic        mem_clr, pre_we;
  logic [11:0] pre_addr;
  logic [31:0] pre_data;
  logic [31:0] dut_mem   [4096];
  logic [31:0] model_mem [4096];

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  csr_access_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .exu_req_valid_i  (exu_req_valid),
    .exu_req_ready_o  (exu_req_ready),
    .exu_csr_addr_i   (exu_csr_addr),
    .exu_op_i         (exu_op),
    .exu_wen_i        (exu_wen),
    .exu_op1_i        (exu_op1),
    .exu_resp_valid_o (exu_resp_valid),
    .exu_resp_ready_i (exu_resp_ready),
    .exu_resp_rdata_o (exu_resp_rdata),
    .int_assert_i     (int_assert),
    .int_req_valid_i  (int_req_valid),
    .int_req_ready_o  (int_req_ready),
    .int_csr_addr_i   (int_csr_addr),
    .int_csr_wdata_i  (int_csr_wdata),
    .csr_raddr_o      (csr_raddr),
    .csr_rdata_i      (csr_rdata),
    .csr_we_o         (csr_we),
    .csr_waddr_o      (csr_waddr),
    .csr_wdata_o      (csr_wdata),
    .busy_o           (busy)
  );

  // Bench-owned register file: combinational read, writes from the DUT or presets.
  assign csr_rdata = dut_mem[csr_raddr];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4096; i++) dut_mem[i] <= 32'h0;
    end else if (csr_we) begin
      dut_mem[csr_waddr] <= csr_wdata;
    end else if (pre_we) begin
      dut_mem[pre_addr] <= pre_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] apply_op(input logic [1:0] op, input logic [31:0] old_v,
                                           input logic [31:0] op1);
    if (op == 2'b01) return op1;
    if (op == 2'b10) return old_v | op1;
    if (op == 2'b11) return old_v & ~op1;
    return old_v;
  endfunction

  // Reference model: one outstanding transaction and the cycle count since it was accepted.
  int          m_kind = 0;   // 0 none, 1 INT write, 2 EXU access
  int          m_step = 0;
  logic [11:0] m_addr;
  logic [31:0] m_data, m_old;
  logic [1:0]  m_op;
  logic        m_wen;
  logic        e_ir, e_er, e_we, e_rv, e_busy;
  logic [11:0] e_ra, e_wa;
  logic [31:0] e_wd, e_rd;

  always @(negedge clk) begin
    e_ir = 0; e_er = 0; e_we = 0; e_rv = 0; e_busy = 0;
    e_ra = '0; e_wa = '0; e_wd = '0; e_rd = '0;
    if (!rst) begin
      if (m_kind == 0) begin
        e_ir = 1'b1;
        e_er = !int_req_valid && !int_assert;
      end else begin
        e_busy = 1'b1;
        if (m_kind == 1) begin
          e_we = 1'b1; e_wa = m_addr; e_wd = m_data;
        end else if (m_step == 1) begin
          e_ra = m_addr;
        end else begin
          if (m_step == 2 && m_wen && m_op != 2'b00 && !int_assert) begin
            e_we = 1'b1; e_wa = m_addr; e_wd = apply_op(m_op, m_old, m_data);
          end
          if (!int_assert) begin
            e_rv = 1'b1; e_rd = m_old;
          end
        end
      end
    end
    chk("int_req_ready",  32'(int_req_ready),  32'(e_ir));
    chk("exu_req_ready",  32'(exu_req_ready),  32'(e_er));
    chk("csr_raddr",      32'(csr_raddr),      32'(e_ra));
    chk("csr_we",         32'(csr_we),         32'(e_we));
    chk("csr_waddr",      32'(csr_waddr),      32'(e_wa));
    chk("csr_wdata",      csr_wdata,           e_wd);
    chk("exu_resp_valid", 32'(exu_resp_valid), 32'(e_rv));
    chk("exu_resp_rdata", exu_resp_rdata,      e_rd);
    chk("busy",           32'(busy),           32'(e_busy));

    if (mem_clr) for (int i = 0; i < 4096; i++) model_mem[i] = 32'h0;
    else if (pre_we) model_mem[pre_addr] = pre_data;
    if (e_we) model_mem[e_wa] = e_wd;
    if (rst) begin
      m_kind = 0;
    end else if (m_kind == 0) begin
      if (int_req_valid) begin
        m_kind = 1; m_step = 1; m_addr = int_csr_addr; m_data = int_csr_wdata;
      end else if (exu_req_valid && e_er) begin
        m_kind = 2; m_step = 1; m_addr = exu_csr_addr; m_data = exu_op1;
        m_op = exu_op; m_wen = exu_wen;
      end
    end else if (m_kind == 1) begin
      m_kind = 0;
    end else if (m_step == 1) begin
      if (int_assert) m_kind = 0;
      else begin m_old = model_mem[m_addr]; m_step = 2; end
    end else begin
      if (int_assert || exu_resp_ready) m_kind = 0;
      else m_step = 3;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    exu_req_valid = 0; int_req_valid = 0; int_assert = 0; exu_resp_ready = 1;
    pre_we = 0;
  endtask

  task automatic preset(input logic [11:0] a, input logic [31:0] d);
    pre_we = 1; pre_addr = a; pre_data = d;
    tick();
    pre_we = 0;
  endtask

  task automatic exu_req(input logic [11:0] a, input logic [1:0] op, input logic wen,
                         input logic [31:0] op1);
    exu_req_valid = 1; exu_csr_addr = a; exu_op = op; exu_wen = wen; exu_op1 = op1;
  endtask

  initial begin
    rst = 1; mem_clr = 1; quiet();
    exu_csr_addr = '0; exu_op = '0; exu_wen = 0; exu_op1 = '0;
    int_csr_addr = '0; int_csr_wdata = '0; pre_addr = '0; pre_data = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst int_ready", 32'(int_req_ready), 32'h0);
    chk("rst exu_ready", 32'(exu_req_ready), 32'h0);
    chk("rst busy",      32'(busy),          32'h0);
    tick();
    rst = 0; mem_clr = 0;
    tick();

    // CSRRS 0x300: old 0x8 | 0x80
    preset(12'h300, 32'h8);
    exu_req(12'h300, 2'b10, 1, 32'h80);
    @(negedge clk); chk("t1 accept", 32'(exu_req_ready), 32'h1);
    tick(); exu_req_valid = 0;
    @(negedge clk); chk("t1 raddr", 32'(csr_raddr), 32'h300);
    tick();
    @(negedge clk);
    chk("t1 we", 32'(csr_we), 32'h1);
    chk("t1 wdata", csr_wdata, 32'h88);
    chk("t1 rdata", exu_resp_rdata, 32'h8);
    tick();
    @(negedge clk); chk("t1 idle", 32'(busy), 32'h0);
    tick();

    // CSRRC with response backpressure for three cycles
    preset(12'h301, 32'hFFFF_FFFF);
    exu_req(12'h301, 2'b11, 1, 32'h0F); exu_resp_ready = 0;
    tick(); exu_req_valid = 0;
    tick();
    @(negedge clk);
    chk("t2 we", 32'(csr_we), 32'h1);
    chk("t2 wdata", csr_wdata, 32'hFFFF_FFF0);
    chk("t2 rdata", exu_resp_rdata, 32'hFFFF_FFFF);
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k == 2) exu_resp_ready = 1;
      @(negedge clk);
      chk("t2 hold we", 32'(csr_we), 32'h0);
      chk("t2 hold valid", 32'(exu_resp_valid), 32'h1);
      chk("t2 hold rdata", exu_resp_rdata, 32'hFFFF_FFFF);
    end
    tick();
    @(negedge clk);
    chk("t2 idle", 32'(busy), 32'h0);
    chk("t2 mem", dut_mem[12'h301], 32'hFFFF_FFF0);
    tick();

    // INT and EXU requesting together: INT wins
    int_req_valid = 1; int_csr_addr = 12'h341; int_csr_wdata = 32'h1234;
    exu_req(12'h300, 2'b01, 1, 32'h55);
    @(negedge clk);
    chk("t3 int_ready", 32'(int_req_ready), 32'h1);
    chk("t3 exu_ready", 32'(exu_req_ready), 32'h0);
    tick(); int_req_valid = 0;
    @(negedge clk);
    chk("t3 int waddr", 32'(csr_waddr), 32'h341);
    chk("t3 int wdata", csr_wdata, 32'h1234);
    tick();
    @(negedge clk); chk("t3 exu accept", 32'(exu_req_ready), 32'h1);
    tick(); exu_req_valid = 0;
    tick();
    @(negedge clk);
    chk("t3 exu we", 32'(csr_we), 32'h1);
    chk("t3 exu wdata", csr_wdata, 32'h55);
    tick();

    // Interrupt during the write phase of CSRRW 0x305
    exu_req(12'h305, 2'b01, 1, 32'hDEAD);
    tick(); exu_req_valid = 0;
    tick(); int_assert = 1;
    @(negedge clk);
    chk("t4 we", 32'(csr_we), 32'h0);
    chk("t4 valid", 32'(exu_resp_valid), 32'h0);
    tick(); int_assert = 0;
    @(negedge clk); chk("t4 idle", 32'(busy), 32'h0);
    tick();

    // CSRRS with wen=0: read only
    preset(12'h302, 32'hABCD);
    exu_req(12'h302, 2'b10, 0, 32'hFF);
    tick(); exu_req_valid = 0;
    tick();
    @(negedge clk);
    chk("t5 we", 32'(csr_we), 32'h0);
    chk("t5 rdata", exu_resp_rdata, 32'hABCD);
    tick();

    // Reset while in the read phase
    exu_req(12'h303, 2'b01, 1, 32'h1);
    tick(); exu_req_valid = 0; rst = 1;
    @(negedge clk);
    chk("t6 rst raddr", 32'(csr_raddr), 32'h0);
    chk("t6 rst int_ready", 32'(int_req_ready), 32'h0);
    tick(); rst = 0;
    @(negedge clk);
    chk("t6 busy", 32'(busy), 32'h0);
    chk("t6 we", 32'(csr_we), 32'h0);
    tick();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      rst            = ($urandom_range(0, 199) == 0);
      int_req_valid  = ($urandom_range(0, 9) < 2);
      int_csr_addr   = 12'h300 + 12'($urandom_range(0, 7));
      int_csr_wdata  = $urandom;
      exu_req_valid  = ($urandom_range(0, 9) < 6);
      exu_csr_addr   = 12'h300 + 12'($urandom_range(0, 7));
      exu_op         = 2'($urandom_range(0, 3));
      exu_wen        = ($urandom_range(0, 3) != 0);
      exu_op1        = $urandom;
      int_assert     = ($urandom_range(0, 9) == 0);
      exu_resp_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    rst = 0; quiet();
    repeat (5) tick();
    for (int a = 12'h300; a < 12'h308; a++) chk("final mem", dut_mem[a], model_mem[a]);
    chk("final mem 341", dut_mem[12'h341], model_mem[12'h341]);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
